dem_switch_layer: RTL and testbench

Parametrised single layer of the DEM-DAC switching tree, built from N_NODES independent switching nodes. Each node splits an unsigned element count into two halves, and the halves always sum to the input. For odd inputs, a ±1 imbalance is steered by a runtime-selectable rule: static, first-order mismatch shaping, shaping with dithered tie-break, or pure random. Layers chain output-to-input to build a tree of any depth. Each layer is registered and adds one cycle, with a valid qualifier.

---
 rtl/dem_switch_layer_pkg.sv | 15 +
 rtl/dem_switch_node.sv | 57 +++++
 rtl/dem_switch_layer.sv | 56 +++++
 tb/tb_dem_switch_layer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/dem_switch_layer_pkg.sv
// lib_switchblock_pkg: shared widths, DEM mode encoding, switching-value codes and LFSR constants.
package lib_switchblock_pkg;
    localparam int INPUT_WIDTH = 8;
    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    typedef enum logic [1:0] {
        STATIC       = 2'b00,
        SHAPE        = 2'b01,
        SHAPE_DITHER = 2'b10,
        RANDOM       = 2'b11
    } dem_mode_e;
    localparam logic [1:0] S_ZERO = 2'b00;
    localparam logic [1:0] S_POS  = 2'b01;
    localparam logic [1:0] S_NEG  = 2'b11;
endpackage

// File: rtl/dem_switch_node.sv
// dem_switch_node: one DEM switching node; splits x into two registered halves steered by a first-order acc.
module dem_switch_node
    import lib_switchblock_pkg::*;
#(
    parameter int W = INPUT_WIDTH
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         valid_i,
    input  logic         tie_i,
    input  logic         clear_acc_i,
    input  dem_mode_e    mode_i,
    input  logic [W-1:0] x_i,
    output logic [W-1:0] x1_o,
    output logic [W-1:0] x2_o,
    output logic [1:0]   s_o
);
    logic [1:0] acc_q, acc_d, acc_eff, dith, shaped, s_new, s_d, s_q;
    logic signed [2:0] acc_sum;
    logic [W:0] sx, sum, dif;
    logic [W-1:0] x1_d, x1_q, x2_d, x2_q;

    always_comb begin
        acc_eff = clear_acc_i ? S_ZERO : acc_q;
        dith    = tie_i ? S_POS : S_NEG;
        shaped  = (acc_eff != S_ZERO) ? -acc_eff : (mode_i == SHAPE_DITHER ? dith : S_POS);
        s_new   = !x_i[0] ? S_ZERO : mode_i == STATIC ? S_POS : mode_i == RANDOM ? dith : shaped;
        acc_sum = $signed({acc_eff[1], acc_eff}) + $signed({s_new[1], s_new});
        // RANDOM can push the sum to +-2; clamp so acc stays within -1..+1
        acc_d   = !valid_i ? acc_q : mode_i == STATIC ? S_ZERO :
                  acc_sum > 3'sd1 ? S_POS : acc_sum < -3'sd1 ? S_NEG : acc_sum[1:0];
        sx      = {{(W-1){s_new[1]}}, s_new};
        sum     = {1'b0, x_i} + sx;
        dif     = {1'b0, x_i} - sx;
        x1_d    = valid_i ? sum[W:1] : x1_q;
        x2_d    = valid_i ? dif[W:1] : x2_q;
        s_d     = valid_i ? s_new : s_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q <= S_ZERO;
            x1_q  <= '0;
            x2_q  <= '0;
            s_q   <= S_ZERO;
        end else begin
            acc_q <= acc_d;
            x1_q  <= x1_d;
            x2_q  <= x2_d;
            s_q   <= s_d;
        end
    end

    assign x1_o = x1_q;
    assign x2_o = x2_q;
    assign s_o  = s_q;
endmodule

// File: rtl/dem_switch_layer.sv
// dem_switch_layer: one registered layer of N_NODES DEM switching nodes sharing a Fibonacci LFSR.
module dem_switch_layer #(
    parameter int N_NODES = 4,
    parameter int INPUT_WIDTH = lib_switchblock_pkg::INPUT_WIDTH,
    parameter logic [lib_switchblock_pkg::LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             valid_i,
    input  logic [1:0]                       mode_i,
    input  logic [N_NODES*INPUT_WIDTH-1:0]   x_in_i,
    output logic                             valid_o,
    output logic [2*N_NODES*INPUT_WIDTH-1:0] x_out_o,
    output logic [2*N_NODES-1:0]             s_out_o
);
    localparam int LW = lib_switchblock_pkg::LFSR_W;
    logic [LW-1:0] lfsr_q, lfsr_d;
    lib_switchblock_pkg::dem_mode_e mode_q, mode_d;
    logic valid_q, valid_d, clear_acc;

    always_comb begin
        lfsr_d    = valid_i ? {lfsr_q[LW-2:0], ^(lfsr_q & lib_switchblock_pkg::LFSR_TAPS)} : lfsr_q;
        mode_d    = valid_i ? lib_switchblock_pkg::dem_mode_e'(mode_i) : mode_q;
        valid_d   = valid_i;
        clear_acc = valid_i && (mode_i != mode_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lfsr_q  <= LFSR_SEED;
            mode_q  <= lib_switchblock_pkg::STATIC;
            valid_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;

    for (genvar k = 0; k < N_NODES; k++) begin : g_node
        dem_switch_node #(.W(INPUT_WIDTH)) u_node (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .valid_i     (valid_i),
            .tie_i       (lfsr_q[k]),
            .clear_acc_i (clear_acc),
            .mode_i      (lib_switchblock_pkg::dem_mode_e'(mode_i)),
            .x_i         (x_in_i[k*INPUT_WIDTH +: INPUT_WIDTH]),
            .x1_o        (x_out_o[2*k*INPUT_WIDTH +: INPUT_WIDTH]),
            .x2_o        (x_out_o[(2*k+1)*INPUT_WIDTH +: INPUT_WIDTH]),
            .s_o         (s_out_o[2*k +: 2])
        );
    end
endmodule

// File: tb/tb_dem_switch_layer.sv
// tb_dem_switch_layer: directed self-checking bench for dem_switch_layer with immediate assertions.
module tb_dem_switch_layer;
    import lib_switchblock_pkg::*;
    localparam int N = 4;
    localparam int W = INPUT_WIDTH;

    logic clk, reset_i, valid_i, valid_o;
    logic [1:0] mode_i;
    logic [N*W-1:0] x_in_i;
    logic [2*N*W-1:0] x_out_o;
    logic [2*N-1:0] s_out_o;
    int total, bad;
    logic [15:0] lm, pre;
    logic [2*W+1:0] ex [N];

    dem_switch_layer #(.N_NODES(N), .INPUT_WIDTH(W), .LFSR_SEED(16'hACE1)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .mode_i  (mode_i),
        .x_in_i  (x_in_i),
        .valid_o (valid_o),
        .x_out_o (x_out_o),
        .s_out_o (s_out_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] nx(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [N*W-1:0] xv(input logic [W-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [2*W+1:0] nobs(input int k);
        return {x_out_o[2*k*W +: W], x_out_o[(2*k+1)*W +: W], s_out_o[2*k +: 2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] m, input logic [N*W-1:0] x, input logic r);
        reset_i = r;
        valid_i = v;
        mode_i  = m;
        x_in_i  = x;
        @(posedge clk);
        #1;
        if (r) lm = 16'hACE1;
        else if (v) lm = nx(lm);
        reset_i = 1'b0;
        valid_i = 1'b0;
    endtask

    initial begin
        clk = 1'b0; reset_i = 1'b1; valid_i = 1'b0; mode_i = 2'b00; x_in_i = '0;
        total = 0; bad = 0; lm = 16'hACE1;
        step(0, STATIC, '0, 1);
        step(0, STATIC, '0, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_x", x_out_o, 0);
        chk("rst_s", s_out_o, 0);

        step(1, SHAPE, xv(5, 5, 0, 0), 0);
        chk("first_valid", valid_o, 1);
        chk("shape1_n0", nobs(0), {8'd3, 8'd2, S_POS});
        chk("shape1_n2", nobs(2), {8'd0, 8'd0, S_ZERO});
        step(1, SHAPE, xv(5, 5, 0, 0), 0);
        chk("shape2_n0", nobs(0), {8'd2, 8'd3, S_NEG});
        step(1, SHAPE, xv(5, 5, 0, 0), 0);
        chk("shape3_n0", nobs(0), {8'd3, 8'd2, S_POS});
        step(1, SHAPE, xv(6, 6, 0, 0), 0);
        chk("shape_even", nobs(0), {8'd3, 8'd3, S_ZERO});
        step(1, SHAPE, xv(5, 5, 0, 0), 0);
        chk("shape_after_even", nobs(0), {8'd2, 8'd3, S_NEG});
        step(1, SHAPE, xv(5, 5, 0, 0), 0);
        chk("shape6_n1", nobs(1), {8'd3, 8'd2, S_POS});
        step(0, SHAPE, xv(5, 5, 0, 0), 0);
        chk("gap_valid", valid_o, 0);
        chk("gap_hold", nobs(0), {8'd3, 8'd2, S_POS});

        // acc is +1 on nodes 0/1; pre-advance LFSR here is 16'h3879 (bit0=1, bit1=0)
        step(1, SHAPE_DITHER, xv(5, 5, 0, 0), 0);
        chk("switch_n0_tie1", nobs(0), {8'd3, 8'd2, S_POS});
        chk("switch_n1_tie0", nobs(1), {8'd2, 8'd3, S_NEG});
        step(1, SHAPE_DITHER, xv(5, 5, 0, 0), 0);
        chk("dither_n0", nobs(0), {8'd2, 8'd3, S_NEG});
        chk("dither_n1", nobs(1), {8'd3, 8'd2, S_POS});

        for (int i = 0; i < 4; i++) begin
            step(1, STATIC, xv(7, 8'hFF, 1, 0), 0);
            chk("static7", nobs(0), {8'd4, 8'd3, S_POS});
            chk("static_max", nobs(1), {8'd128, 8'd127, S_POS});
            chk("static_one", nobs(2), {8'd1, 8'd0, S_POS});
            chk("static_zero", nobs(3), {8'd0, 8'd0, S_ZERO});
        end

        step(1, SHAPE, xv(5, 0, 0, 0), 0);
        chk("pre_rst_n0", nobs(0), {8'd3, 8'd2, S_POS});
        step(1, SHAPE, xv(5, 0, 0, 0), 1);
        chk("midrst_valid", valid_o, 0);
        chk("midrst_x", x_out_o, 0);
        chk("midrst_s", s_out_o, 0);
        step(1, SHAPE, xv(5, 1, 0, 0), 0);
        chk("post_rst_valid", valid_o, 1);
        chk("post_rst_n0", nobs(0), {8'd3, 8'd2, S_POS});
        chk("post_rst_n1", nobs(1), {8'd1, 8'd0, S_POS});

        step(0, RANDOM, '0, 1);
        for (int i = 0; i < 64; i++) begin
            if (i % 8 == 5) begin
                step(0, RANDOM, xv(9, 9, 9, 9), 0);
                chk("rnd_gap_valid", valid_o, 0);
                for (int k = 0; k < N; k++) chk("rnd_gap_hold", nobs(k), ex[k]);
            end
            pre = lm;
            step(1, RANDOM, xv(9, 9, 9, 9), 0);
            for (int k = 0; k < N; k++) begin
                ex[k] = pre[k] ? {8'd5, 8'd4, S_POS} : {8'd4, 8'd5, S_NEG};
                chk("rnd", nobs(k), ex[k]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
